// File: rtl/deser_pkg.sv
// deser_pkg: shared constants and helpers for the deserializer.
//   FRAME_EXTRA : number of extra trailing bits per frame (1 when the
//                 DESER_PARITY_EN macro is defined, else 0).
//   cnt_width() : bit counter width for a given data WIDTH.
package deser_pkg;

`ifdef DESER_PARITY_EN
    localparam int unsigned FRAME_EXTRA = 1;
`else
    localparam int unsigned FRAME_EXTRA = 0;
`endif

    // The counter must hold 0..FRAME-1; sized as $clog2(FRAME+1).
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + FRAME_EXTRA + 1);
    endfunction

endpackage

// File: rtl/deser_collector.sv
// deser_collector: bit counter plus shift register for the deserializer.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   accept      : a serial bit is taken this cycle
//   bit_in      : the serial bit
//   at_last     : counter is at the final bit position of the frame
//   frame_done  : the final bit of a frame is accepted this cycle
//   frame_word  : complete frame (stored bits plus the incoming final bit),
//                 valid when frame_done is high
module deser_collector
    import deser_pkg::*;
#(
    parameter int unsigned FRAME = 8,
    parameter int unsigned CW    = cnt_width(FRAME - FRAME_EXTRA)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic             bit_in,
    output logic             at_last,
    output logic             frame_done,
    output logic [FRAME-1:0] frame_word
);

    logic [CW-1:0]    count;
    // Only positions 0..FRAME-2 are stored; the final bit is taken straight
    // from bit_in at the load edge.
    logic [FRAME-2:0] sreg;

    assign at_last    = (count == CW'(FRAME - 1));
    assign frame_done = accept && at_last;
    assign frame_word = {bit_in, sreg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            sreg  <= '0;
        end else if (accept) begin
            if (at_last)
                count <= '0;
            else
                count <= count + 1'b1;
            // Bit k of the frame lands in position k (LSB first).
            for (int unsigned i = 0; i < FRAME - 1; i++) begin
                if (count == CW'(i))
                    sreg[i] <= bit_in;
            end
        end
    end

endmodule

// File: rtl/deserializer.sv
// deserializer: serial-to-parallel converter, LSB-first, double-buffered.
// Optional feature: define DESER_PARITY_EN to expect a trailing even-parity
// bit per frame and report parity_err alongside the word.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   serial_valid    : serial_data carries a bit this cycle
//   serial_data     : serial bit
//   serial_ready    : a bit can be accepted this cycle
//   parallel_valid  : parallel_data holds a complete word
//   parallel_data   : assembled word (WIDTH bits)
//   parallel_ready  : consumer takes the word this cycle
//   parity_err      : (DESER_PARITY_EN only) parity check result of the word
module deserializer
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_valid,
    input  logic             serial_data,
    output logic             serial_ready,
    output logic             parallel_valid,
    output logic [WIDTH-1:0] parallel_data,
    input  logic             parallel_ready
`ifdef DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int unsigned FRAME = WIDTH + FRAME_EXTRA;
    localparam int unsigned CW    = cnt_width(WIDTH);

    logic             accept;
    logic             at_last;
    logic             frame_done;
    logic [FRAME-1:0] frame_word;

    // Only the final bit stalls, and only when the held word is not being
    // drained this cycle; combinational from parallel_ready by design.
    assign serial_ready = !(at_last && parallel_valid && !parallel_ready);
    assign accept       = serial_valid && serial_ready;

    deser_collector #(
        .FRAME (FRAME),
        .CW    (CW)
    ) u_collector (
        .clk        (clk),
        .rst        (rst),
        .accept     (accept),
        .bit_in     (serial_data),
        .at_last    (at_last),
        .frame_done (frame_done),
        .frame_word (frame_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parallel_valid <= 1'b0;
            parallel_data  <= '0;
`ifdef DESER_PARITY_EN
            parity_err     <= 1'b0;
`endif
        end else if (frame_done) begin
            // A load wins over a simultaneous drain: valid stays high.
            parallel_valid <= 1'b1;
            parallel_data  <= frame_word[WIDTH-1:0];
`ifdef DESER_PARITY_EN
            parity_err     <= ^frame_word;
`endif
        end else if (parallel_ready) begin
            parallel_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed self-checking bench for deserializer (WIDTH=8).
// Builds with or without DESER_PARITY_EN.
module tb_deserializer;

    localparam int unsigned WIDTH = 8;
`ifdef DESER_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             serial_valid;
    logic             serial_data;
    logic             serial_ready;
    logic             parallel_valid;
    logic [WIDTH-1:0] parallel_data;
    logic             parallel_ready;
`ifdef DESER_PARITY_EN
    logic             parity_err;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    deserializer #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_valid   (serial_valid),
        .serial_data    (serial_data),
        .serial_ready   (serial_ready),
        .parallel_valid (parallel_valid),
        .parallel_data  (parallel_data),
        .parallel_ready (parallel_ready)
`ifdef DESER_PARITY_EN
        ,
        .parity_err     (parity_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial_valid = 1'b1;
        serial_data  = b;
        step();
    endtask

    // Frame bits for a data word, with correct even parity when enabled.
    function automatic logic [FRAME-1:0] frame_of(input logic [WIDTH-1:0] d);
        logic [FRAME-1:0] f;
        f = '0;
        f[WIDTH-1:0] = d;
`ifdef DESER_PARITY_EN
        f[WIDTH] = ^d;
`endif
        return f;
    endfunction

    initial begin
        logic [FRAME-1:0] s;

        rst            = 1'b1;
        serial_valid   = 1'b0;
        serial_data    = 1'b0;
        parallel_ready = 1'b1;
        #12;
        chk("rst_valid", parallel_valid, 0);
        chk("rst_data",  parallel_data,  0);
        chk("rst_sready", serial_ready,  1);
        rst = 1'b0;
        step();

        // 1: single word A5, ready always high
        s = frame_of(8'hA5);
        for (int unsigned i = 0; i < FRAME; i++) begin
            send_bit(s[0]);
            s = s >> 1;
            if (i == FRAME - 2) chk("t1_pre_valid", parallel_valid, 0);
        end
        chk("t1_valid", parallel_valid, 1);
        chk("t1_data",  parallel_data,  32'hA5);
        serial_valid = 1'b0;
        step();
        chk("t1_pulse_end", parallel_valid, 0);

        // 2: back-to-back 3C, C3
        s = frame_of(8'h3C);
        for (int unsigned i = 0; i < FRAME; i++) begin
            send_bit(s[0]);
            s = s >> 1;
        end
        chk("t2_valid_a", parallel_valid, 1);
        chk("t2_data_a",  parallel_data,  32'h3C);
        s = frame_of(8'hC3);
        for (int unsigned i = 0; i < FRAME; i++) begin
            send_bit(s[0]);
            s = s >> 1;
            chk("t2_sready", serial_ready, 1);
            if (i < FRAME - 1) chk("t2_gap_valid", parallel_valid, 0);
        end
        chk("t2_valid_b", parallel_valid, 1);
        chk("t2_data_b",  parallel_data,  32'hC3);
        serial_valid = 1'b0;
        step();
        chk("t2_pulse_end", parallel_valid, 0);

        // 3: backpressure, 11 held, final bit of 22 stalled
        parallel_ready = 1'b0;
        s = frame_of(8'h11);
        for (int unsigned i = 0; i < FRAME; i++) begin
            send_bit(s[0]);
            s = s >> 1;
        end
        chk("t3_valid_a", parallel_valid, 1);
        chk("t3_data_a",  parallel_data,  32'h11);
        s = frame_of(8'h22);
        for (int unsigned i = 0; i < FRAME - 1; i++) begin
            send_bit(s[0]);
            s = s >> 1;
        end
        chk("t3_hold_valid", parallel_valid, 1);
        chk("t3_hold_data",  parallel_data,  32'h11);
        serial_valid = 1'b1;
        serial_data  = s[0];
        #1;
        chk("t3_stall", serial_ready, 0);
        step();
        chk("t3_stall_valid", parallel_valid, 1);
        chk("t3_stall_data",  parallel_data,  32'h11);
        chk("t3_stall2",      serial_ready,   0);
        parallel_ready = 1'b1;
        #1;
        chk("t3_release", serial_ready, 1);
        step();
        chk("t3_valid_b", parallel_valid, 1);
        chk("t3_data_b",  parallel_data,  32'h22);
        serial_valid = 1'b0;
        step();
        chk("t3_drained", parallel_valid, 0);

        // 4: 96 with idle gaps carrying garbage data
        s = frame_of(8'h96);
        for (int unsigned i = 0; i < FRAME; i++) begin
            for (int unsigned g = 0; g < i % 3; g++) begin
                serial_valid = 1'b0;
                serial_data  = 1'($urandom_range(0, 1));
                step();
            end
            if (i == FRAME - 1) chk("t4_pre_valid", parallel_valid, 0);
            send_bit(s[0]);
            s = s >> 1;
        end
        chk("t4_valid", parallel_valid, 1);
        chk("t4_data",  parallel_data,  32'h96);
        serial_valid = 1'b0;
        step();

        // 5: asynchronous reset mid-word with a held output word
        parallel_ready = 1'b0;
        s = frame_of(8'h5A);
        for (int unsigned i = 0; i < FRAME; i++) begin
            send_bit(s[0]);
            s = s >> 1;
        end
        chk("t5_held", parallel_data, 32'h5A);
        s = frame_of(8'h0F);
        for (int unsigned i = 0; i < 4; i++) begin
            send_bit(s[0]);
            s = s >> 1;
        end
        serial_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid",  parallel_valid, 0);
        chk("t5_rst_data",   parallel_data,  0);
        chk("t5_rst_sready", serial_ready,   1);
        #2;
        rst = 1'b0;
        parallel_ready = 1'b1;
        step();
        s = frame_of(8'hFF);
        for (int unsigned i = 0; i < FRAME; i++) begin
            send_bit(s[0]);
            s = s >> 1;
            if (i < FRAME - 1) chk("t5_no_leftover", parallel_valid, 0);
        end
        chk("t5_valid", parallel_valid, 1);
        chk("t5_data",  parallel_data,  32'hFF);
        serial_valid = 1'b0;
        step();

`ifdef DESER_PARITY_EN
        // 6: parity good, then parity bad
        s = {1'b0, 8'hA5};
        for (int unsigned i = 0; i < FRAME; i++) begin
            send_bit(s[0]);
            s = s >> 1;
        end
        chk("t6_ok_valid", parallel_valid, 1);
        chk("t6_ok_perr",  parity_err,     0);
        s = {1'b1, 8'hA5};
        for (int unsigned i = 0; i < FRAME; i++) begin
            send_bit(s[0]);
            s = s >> 1;
        end
        chk("t6_bad_valid", parallel_valid, 1);
        chk("t6_bad_perr",  parity_err,     1);
        chk("t6_bad_data",  parallel_data,  32'hA5);
        serial_valid = 1'b0;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Serial-to-parallel converter: the receive-side counterpart of a mux-based serializer.
- Collects 1-bit serial beats LSB-first into WIDTH-bit words and presents each word on a registered valid/ready output.
- Sits between a bit-serial link and word-wide consumers.
- Double-buffered (shift register plus output register), so sustained throughput is one word per WIDTH accepted bits with no bubbles.

Parameters:
- WIDTH, 8, parallel word width in bits; must be >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- serial_valid  input  1  serial_data carries a bit this cycle.
- serial_data  input  1  serial bit.
- serial_ready  output  1  deserializer can accept a bit this cycle.
- parallel_valid  output  1  parallel_data holds a complete word.
- parallel_data  output  WIDTH  assembled word.
- parallel_ready  input  1  consumer takes the word this cycle.
- parity_err  output  1  present only with DESER_PARITY_EN.

Behaviour:
- Reset (asynchronous, immediate):
  - bit counter = 0, shift register = 0.
  - parallel_valid = 0, parallel_data = 0, parity_err = 0.
  - serial_ready = 1 while in reset and after it.
  - Reset mid-word discards the partial word and any held output word.
- Bit accept: serial_valid && serial_ready in the same cycle.
  - Accepted bit k of a frame (k = 0..FRAME-1) lands in position k, so bit 0 is the word LSB.
  - Cycles with serial_valid = 0 change nothing.
- Frame length: FRAME = WIDTH, or WIDTH+1 with DESER_PARITY_EN.
  - Counter width is $clog2(FRAME+1).
  - Counter wraps to 0 on accepting bit FRAME-1.
- Load: on accepting bit FRAME-1, the full word is written to the output register at that same edge.
  - parallel_valid is high in the first cycle after the last bit is accepted (latency 1 cycle).
- Output hold:
  - parallel_valid and parallel_data stay stable until a cycle with parallel_valid && parallel_ready.
  - parallel_valid clears after that cycle unless a new word loads at the same edge.
  - Simultaneous drain and load: new word replaces old; parallel_valid stays 1.
- Stall: serial_ready = !(counter == FRAME-1 && parallel_valid && !parallel_ready).
  - Only the final bit of a frame is ever stalled.
  - This is a combinational path from parallel_ready to serial_ready; it is intended.
- No bits are dropped or duplicated under any valid/ready pattern.
- serial_data is ignored when serial_valid = 0.

Optional Feature:
- Macro DESER_PARITY_EN.
- Defined:
  - Each frame carries one extra trailing even-parity bit after the WIDTH data bits.
  - parity_err is registered alongside parallel_data: 1 if XOR of the data bits and the parity bit is 1.
  - parity_err is meaningful only while parallel_valid = 1.
  - The word is still delivered on error.
- Undefined:
  - FRAME = WIDTH; no parity bit is consumed.
  - parity_err port is absent.

Decomposition:
- Package deser_pkg:
  - FRAME_EXTRA constant (0/1, selected by the macro).
  - Function returning the counter width for a given WIDTH.
- One natural sub-module, deser_collector: counter plus shift register, with an accept input and a frame_done/word output.
- The top level holds the output register and the handshake logic.

Test Plan:
1. WIDTH=8, parallel_ready=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> parallel_valid pulses for exactly 1 cycle, one cycle after the 8th bit, with parallel_data=8'hA5.
2. Continuous serial_valid=1, words 8'h3C then 8'hC3, parallel_ready=1 -> two valid pulses exactly 8 cycles apart with data 3C then C3; serial_ready never drops.
3. parallel_ready=0, send 8'h11 then 8'h22:
   - 11 is held stable.
   - serial_ready=0 while the 8th bit of 22 is presented.
   - Raise parallel_ready for 1 cycle -> 11 is consumed and the stalled bit is accepted the same cycle.
   - parallel_data=22 next cycle.
4. Bits of 8'h96 interleaved with random serial_valid=0 gaps carrying garbage serial_data -> parallel_data=8'h96.
5. Assert rst asynchronously mid-cycle after 4 bits of a word -> outputs go to 0 without waiting for a clock edge; the next full word 8'hFF is delivered correctly with no leftover bits.
6. With DESER_PARITY_EN:
   - 8'hA5 followed by parity bit 0 -> parity_err=0.
   - 8'hA5 followed by parity bit 1 -> parity_err=1 and parallel_data=8'hA5.
